// File: rtl/cam_ctrl_if.sv
// cam_ctrl_if: request/response handshake and CAM port bundle for cam_ctrl
//  master : the environment side (requester, response consumer, CAM device)
//  slave  : the controller side (cam_ctrl)
//  flush, req_*  : lookup requests and re-initialisation
//  rsp_*, full   : lookup results and occupancy status
//  cam_*         : write/search strobes to the CAM and its registered match result
interface cam_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
);
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic              req_insert;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDX_W-1:0]  rsp_index;
    logic              rsp_hit;
    logic              rsp_new;
    logic              full;
    logic              cam_enable;
    logic              cam_write;
    logic [IDX_W-1:0]  cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic [IDX_W-1:0]  cam_out;
    logic              cam_found;

    modport master (
        output flush, req_valid, req_data, req_insert, rsp_ready, cam_out, cam_found,
        input  req_ready, rsp_valid, rsp_index, rsp_hit, rsp_new, full,
               cam_enable, cam_write, cam_addr, cam_data
    );

    modport slave (
        input  flush, req_valid, req_data, req_insert, rsp_ready, cam_out, cam_found,
        output req_ready, rsp_valid, rsp_index, rsp_hit, rsp_new, full,
               cam_enable, cam_write, cam_addr, cam_data
    );
endinterface

// File: rtl/cam_ctrl.sv
// cam_ctrl: initiator for a 16-entry CAM: init, lookup, insert-on-miss, valid/ready response
//  clk, rst : clock and asynchronous active-high reset
//  bus      : cam_ctrl_if slave view
//             flush/req_* in, req_ready out (IDLE only)
//             rsp_index/rsp_hit/rsp_new held with rsp_valid until rsp_ready
//             full when every entry is allocated
//             cam_enable/cam_write/cam_addr/cam_data drive the CAM, cam_out/cam_found come back
module cam_ctrl #(
    parameter int         NB_MEM    = 16,
    parameter int         SIZE_ADDR = 4,
    parameter logic [7:0] FILL      = 8'hFF
) (
    input logic       clk,
    input logic       rst,
    cam_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SEARCH,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [SIZE_ADDR-1:0] ptr_q, ptr_d;
    logic [SIZE_ADDR:0]   count_q, count_d;
    logic [7:0]           key_q, key_d;
    logic                 ins_q, ins_d;
    logic [SIZE_ADDR:0]   idx_q, idx_d;
    logic                 hit_q, hit_d;
    logic                 new_q, new_d;
    logic                 live_q;
    logic                 full_w;

    assign full_w = count_q == (SIZE_ADDR+1)'(NB_MEM);

    // live_q keeps the INIT write strobe low while rst is held, so every output
    // sits at its reset value; the first INIT write happens on the cycle after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live_q <= 1'b0;
        else     live_q <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            key_q   <= '0;
            ins_q   <= 1'b0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            new_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            key_q   <= key_d;
            ins_q   <= ins_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            new_q   <= new_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        key_d   = key_q;
        ins_d   = ins_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        new_d   = new_q;
        case (state_q)
            S_INIT: begin
                if (live_q) begin
                    // ptr wraps back to 0 after the last entry
                    ptr_d   = ptr_q + 1'b1;
                    state_d = (ptr_q == SIZE_ADDR'(NB_MEM-1)) ? S_IDLE : S_INIT;
                end
            end
            S_IDLE: begin
                if (bus.flush) begin
                    state_d = S_INIT;
                    count_d = '0;
                end else if (bus.req_valid) begin
                    key_d   = bus.req_data;
                    ins_d   = bus.req_insert;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                    new_d   = 1'b0;
                    // FILL marks empty entries, so it can never be a stored key
                    state_d = (bus.req_data == FILL) ? S_RESP : S_SEARCH;
                end
            end
            S_SEARCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.cam_found) begin
                    hit_d   = 1'b1;
                    idx_d   = bus.cam_out;
                    state_d = S_RESP;
                end else begin
                    state_d = (ins_q && !full_w) ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                // entries fill in order, so the occupancy count is the next free slot
                count_d = count_q + 1'b1;
                idx_d   = count_q;
                new_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP:  state_d = bus.rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_INIT;
        endcase
    end

    assign bus.req_ready  = state_q == S_IDLE;
    assign bus.rsp_valid  = state_q == S_RESP;
    assign bus.rsp_index  = idx_q;
    assign bus.rsp_hit    = hit_q;
    assign bus.rsp_new    = new_q;
    assign bus.full       = full_w;
    assign bus.cam_enable = state_q == S_SEARCH;
    assign bus.cam_write  = (state_q == S_INIT && live_q) || state_q == S_WRITE;
    assign bus.cam_addr   = (state_q == S_WRITE) ? count_q : {1'b0, ptr_q};
    assign bus.cam_data   = (state_q == S_SEARCH || state_q == S_WRITE) ? key_q : FILL;
endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: randomized scoreboard bench for cam_ctrl with a behavioural CAM and key-list model
module tb_cam_ctrl;
    typedef struct {
        logic [4:0] idx;
        logic       hit;
        logic       nw;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         wr_cnt = 0;
    int         hold_rdy = 0;
    logic       in_rsp = 1'b0;
    logic [6:0] first_rsp;
    logic [7:0] mem [16];
    logic [7:0] ref_keys [$];
    exp_t       sbq [$];

    cam_ctrl_if bus ();

    cam_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, want, cyc);
        end
    endtask

    // behavioural CAM: registered match result one cycle after the search strobe
    always @(posedge clk) begin
        if (bus.cam_write) mem[bus.cam_addr[3:0]] <= bus.cam_data;
        bus.cam_found <= 1'b0;
        bus.cam_out   <= '0;
        if (bus.cam_enable)
            for (int i = 0; i < 16; i++)
                if (mem[i] == bus.cam_data) begin
                    bus.cam_found <= 1'b1;
                    bus.cam_out   <= 5'(i);
                end
    end

    always @(posedge clk) begin
        #1;
        if (hold_rdy > 0) begin
            bus.rsp_ready = 1'b0;
            hold_rdy--;
        end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        logic [6:0] cur;
        exp_t e;
        if (!rst) begin
            check("wr_en_excl", int'(bus.cam_write & bus.cam_enable), 0);
            if (bus.cam_write) wr_cnt++;
            if (bus.req_valid && bus.req_ready && !bus.flush) acc_cyc = cyc + 1;
            if (bus.rsp_valid) begin
                cur = {bus.rsp_index, bus.rsp_hit, bus.rsp_new};
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    first_rsp = cur;
                    check("rsp_expected", sbq.size(), 1);
                    if (sbq.size() > 0) check("rsp_latency", cyc - acc_cyc + 1, sbq[0].lat);
                end else begin
                    check("rsp_stable", int'(cur), int'(first_rsp));
                end
                if (bus.rsp_ready) begin
                    in_rsp = 1'b0;
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("rsp_index", int'(bus.rsp_index), int'(e.idx));
                        check("rsp_hit", int'(bus.rsp_hit), int'(e.hit));
                        check("rsp_new", int'(bus.rsp_new), int'(e.nw));
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, int'(bus.req_ready), 0);
        check({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        check({tag, "_rsp_index"}, int'(bus.rsp_index), 0);
        check({tag, "_rsp_hit"}, int'(bus.rsp_hit), 0);
        check({tag, "_rsp_new"}, int'(bus.rsp_new), 0);
        check({tag, "_full"}, int'(bus.full), 0);
        check({tag, "_cam_enable"}, int'(bus.cam_enable), 0);
        check({tag, "_cam_write"}, int'(bus.cam_write), 0);
        check({tag, "_cam_addr"}, int'(bus.cam_addr), 0);
        check({tag, "_cam_data"}, int'(bus.cam_data), 8'hFF);
    endtask

    task automatic check_init(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check({tag, "_write"}, int'(bus.cam_write), 1);
            check({tag, "_addr"}, int'(bus.cam_addr), i);
            check({tag, "_data"}, int'(bus.cam_data), 8'hFF);
        end
        @(negedge clk);
        check({tag, "_ready_after"}, int'(bus.req_ready), 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.req_ready && n < 100);
        check("req_ready_wait", int'(bus.req_ready), 1);
    endtask

    function automatic logic [7:0] new_key();
        logic [7:0] k;
        int hits [$];
        do begin
            k = 8'($urandom_range(0, 254));
            hits = ref_keys.find_first_index(x) with (x == k);
        end while (hits.size() != 0);
        return k;
    endfunction

    function automatic exp_t model(input logic [7:0] k, input logic ins);
        exp_t e;
        int hits [$];
        hits = ref_keys.find_first_index(x) with (x == k);
        e.idx = '0; e.hit = 1'b0; e.nw = 1'b0; e.lat = 3;
        if (k == 8'hFF) begin
            e.lat = 1;
        end else if (hits.size() != 0) begin
            e.idx = 5'(hits[0]);
            e.hit = 1'b1;
        end else if (ins && ref_keys.size() < 16) begin
            e.idx = 5'(ref_keys.size());
            e.nw  = 1'b1;
            e.lat = 4;
            ref_keys.push_back(k);
        end
        return e;
    endfunction

    task automatic do_req(input logic [7:0] k, input logic ins);
        int n = 0;
        wait_ready();
        sbq.push_back(model(k, ins));
        bus.req_valid  = 1'b1;
        bus.req_data   = k;
        bus.req_insert = ins;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("rsp_drain", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        int w0;
        int n;
        logic [7:0] k;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_data   = '0;
        bus.req_insert = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        check_init("init");
        check("full_after_init", int'(bus.full), 0);

        do_req(8'h3C, 1'b1);
        do_req(8'h3C, 1'b0);

        repeat (30) begin
            n = $urandom_range(0, 9);
            if (n == 0) k = 8'hFF;
            else if (n < 4 && ref_keys.size() > 0) k = ref_keys[$urandom_range(0, ref_keys.size() - 1)];
            else k = 8'($urandom_range(0, 255));
            do_req(k, 1'($urandom_range(0, 1)));
        end

        while (ref_keys.size() < 16) do_req(new_key(), 1'b1);
        @(negedge clk);
        check("full_set", int'(bus.full), 1);
        w0 = wr_cnt;
        do_req(new_key(), 1'b1);
        check("full_no_write", wr_cnt, w0);

        hold_rdy = 8;
        do_req(8'hFF, 1'b0);

        repeat (10) do_req(ref_keys[$urandom_range(0, 15)], 1'($urandom_range(0, 1)));

        wait_ready();
        bus.flush      = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_data   = 8'h3C;
        bus.req_insert = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        ref_keys.delete();
        check("flush_not_ready", int'(bus.req_ready), 0);
        check("flush_full_clear", int'(bus.full), 0);
        check_init("reinit");
        do_req(8'h3C, 1'b0);

        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_data   = 8'h5A;
        bus.req_insert = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.cam_write && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("write_reached", int'(bus.cam_write), 1);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        in_rsp = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hold_quiet", int'(bus.rsp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
